// File: rtl/control_sequencer.sv
// Hardwired fetch-low / fetch-high / execute sequencer that drives every ALUSystem control input.
// Control outputs are decoded combinationally from the state register and the instruction register.
module control_sequencer #(
  parameter bit PC_RESET_CLEAR  = 1'b1,
  parameter bit ILLEGAL_IS_HALT = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] IR_In,
  input  logic        Z_Flag,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [1:0]  SC,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_RESET_CLR = 3'd0,
    S_FETCH_L   = 3'd1,
    S_FETCH_H   = 3'd2,
    S_EXEC      = 3'd3,
    S_HALT      = 3'd4
  } state_e;

  localparam state_e RESET_STATE = PC_RESET_CLEAR ? S_RESET_CLR : S_FETCH_L;

  localparam logic [1:0] FS_DEC   = 2'b00;
  localparam logic [1:0] FS_INC   = 2'b01;
  localparam logic [1:0] FS_LOAD  = 2'b10;
  localparam logic [1:0] FS_CLEAR = 2'b11;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_IMM = 2'b10;

  localparam logic [1:0] ARF_AR = 2'b00;
  localparam logic [1:0] ARF_PC = 2'b10;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_LDM  = 4'h1;
  localparam logic [3:0] OP_STM  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_LDAR = 4'h7;
  localparam logic [3:0] OP_BRA  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_INC  = 4'hA;
  localparam logic [3:0] OP_DEC  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_e     state_q, state_d;
  logic [3:0] opcode_c;
  logic [1:0] rd_c, rs_c;
  logic [3:0] rd_oh_c;
  logic       unused_imm_c;

  assign opcode_c     = IR_In[15:12];
  assign rd_c         = IR_In[11:10];
  assign rs_c         = IR_In[9:8];
  assign rd_oh_c      = 4'b0001 << rd_c;
  // Immediate reaches the datapath through the IR/MuxA/MuxB path, never through the sequencer.
  assign unused_imm_c = ^IR_In[7:0];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Run) begin
      case (state_q)
        S_RESET_CLR: state_d = S_FETCH_L;
        S_FETCH_L:   state_d = S_FETCH_H;
        S_FETCH_H:   state_d = S_EXEC;
        S_EXEC: begin
          if (opcode_c == OP_HLT) state_d = S_HALT;
          else if (opcode_c inside {4'hC, 4'hD, 4'hE} && ILLEGAL_IS_HALT) state_d = S_HALT;
          else state_d = S_FETCH_L;
        end
        S_HALT:      state_d = S_HALT;
        default:     state_d = RESET_STATE;
      endcase
    end
  end

  always_comb begin
    RF_OutASel  = 2'b00;
    RF_OutBSel  = 2'b00;
    RF_FunSel   = 2'b00;
    RF_RegSel   = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    Halted      = (state_q == S_HALT);
    case (state_q)
      S_FETCH_L: SC = 2'd0;
      S_FETCH_H: SC = 2'd1;
      S_EXEC:    SC = 2'd2;
      default:   SC = 2'd3;
    endcase
    // Reset low or Run low forces every control to its idle value.
    if (Reset && Run) begin
      case (state_q)
        S_RESET_CLR: begin
          ARF_RegSel = 3'b111;
          ARF_FunSel = FS_CLEAR;
          RF_RegSel  = 4'b1111;
          RF_FunSel  = FS_CLEAR;
        end
        S_FETCH_L, S_FETCH_H: begin
          Mem_CS      = 1'b0;
          ARF_OutDSel = ARF_PC;
          IR_Enable   = 1'b1;
          IR_LH       = (state_q == S_FETCH_H);
          IR_Funsel   = FS_LOAD;
          ARF_RegSel  = 3'b001;
          ARF_FunSel  = FS_INC;
        end
        S_EXEC: begin
          case (opcode_c)
            OP_LDI: begin
              MuxASel   = SRC_IMM;
              RF_FunSel = FS_LOAD;
              RF_RegSel = rd_oh_c;
            end
            OP_LDM: begin
              Mem_CS      = 1'b0;
              ARF_OutDSel = ARF_AR;
              MuxASel     = SRC_MEM;
              RF_FunSel   = FS_LOAD;
              RF_RegSel   = rd_oh_c;
            end
            OP_STM: begin
              RF_OutASel = rs_c;
              MuxCSel    = 1'b0;
              ALU_FunSel = 4'b0000;
              Mem_CS     = 1'b0;
              Mem_WR     = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              RF_OutASel = rd_c;
              RF_OutBSel = rs_c;
              case (opcode_c)
                OP_ADD:  ALU_FunSel = 4'b0100;
                OP_SUB:  ALU_FunSel = 4'b0110;
                OP_AND:  ALU_FunSel = 4'b0111;
                default: ALU_FunSel = 4'b1000;
              endcase
              MuxASel   = SRC_ALU;
              RF_FunSel = FS_LOAD;
              RF_RegSel = rd_oh_c;
            end
            OP_LDAR: begin
              MuxBSel    = SRC_IMM;
              ARF_FunSel = FS_LOAD;
              ARF_RegSel = 3'b100;
            end
            OP_BRA, OP_BZ: begin
              if (opcode_c == OP_BRA || Z_Flag) begin
                MuxBSel    = SRC_IMM;
                ARF_FunSel = FS_LOAD;
                ARF_RegSel = 3'b001;
              end
            end
            OP_INC: begin
              RF_FunSel = FS_INC;
              RF_RegSel = rd_oh_c;
            end
            OP_DEC: begin
              RF_FunSel = FS_DEC;
              RF_RegSel = rd_oh_c;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small ALUSystem datapath obeys the DUT's controls, and results are
// compared against an instruction-level model of the program plus directed control checks.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Run;
  logic [15:0] IR_In;
  logic        Z_Flag;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [1:0]  SC;
  logic        Halted;

  int n_tests;
  int n_fail;

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .IR_In(IR_In), .Z_Flag(Z_Flag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel),
    .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable),
    .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .SC(SC), .Halted(Halted)
  );

  // ---------------- datapath model driven by the sequencer ----------------
  logic [7:0]  img [256];
  logic [7:0]  mem [256];
  logic [7:0]  rf [4];
  logic [7:0]  ar, sp, pc;
  logic [15:0] ir;
  logic        z;
  logic        dp_load;
  logic [7:0]  alu_a, alu_b, alu_out, arf_c, addr, mem_out, muxa, muxb, muxc;
  logic [32:0] rest_out;

  assign IR_In  = ir;
  assign Z_Flag = z;
  assign rest_out = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel, ARF_OutCSel,
                     ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR,
                     MuxASel, MuxBSel, MuxCSel};

  function automatic logic [7:0] arf_pick(input logic [1:0] sel, input logic [7:0] a,
                                          input logic [7:0] s, input logic [7:0] p);
    case (sel)
      2'b00:   return a;
      2'b01:   return s;
      default: return p;
    endcase
  endfunction

  function automatic logic [7:0] apply_fs(input logic [1:0] fs, input logic [7:0] cur,
                                          input logic [7:0] ld);
    case (fs)
      2'b00:   return cur - 8'd1;
      2'b01:   return cur + 8'd1;
      2'b10:   return ld;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] mux4(input logic [1:0] sel, input logic [7:0] a,
                                      input logic [7:0] m, input logic [7:0] i, input logic [7:0] c);
    case (sel)
      2'b00:   return a;
      2'b01:   return m;
      2'b10:   return i;
      default: return c;
    endcase
  endfunction

  always_comb begin
    alu_a = rf[RF_OutASel];
    alu_b = rf[RF_OutBSel];
    case (ALU_FunSel)
      4'b0100: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = alu_a & alu_b;
      4'b1000: alu_out = alu_a | alu_b;
      default: alu_out = alu_a;
    endcase
    arf_c   = arf_pick(ARF_OutCSel, ar, sp, pc);
    addr    = arf_pick(ARF_OutDSel, ar, sp, pc);
    mem_out = Mem_CS ? 8'h00 : mem[addr];
    muxa    = mux4(MuxASel, alu_out, mem_out, ir[7:0], arf_c);
    muxb    = mux4(MuxBSel, alu_out, mem_out, ir[7:0], arf_c);
    muxc    = MuxCSel ? alu_out : alu_a;
  end

  always @(posedge Clock) begin
    if (dp_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      for (int i = 0; i < 4; i++) rf[i] <= 8'hA5;
      ar <= 8'hA5; sp <= 8'hA5; pc <= 8'hA5; ir <= 16'hFFFF; z <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (RF_RegSel[i]) rf[i] <= apply_fs(RF_FunSel, rf[i], muxa);
      if (ARF_RegSel[2]) ar <= apply_fs(ARF_FunSel, ar, muxb);
      if (ARF_RegSel[1]) sp <= apply_fs(ARF_FunSel, sp, muxb);
      if (ARF_RegSel[0]) pc <= apply_fs(ARF_FunSel, pc, muxb);
      if (IR_Enable && IR_Funsel == 2'b10) begin
        if (IR_LH) ir[15:8] <= mem_out;
        else       ir[7:0]  <= mem_out;
      end
      if (!Mem_CS && Mem_WR) mem[addr] <= muxc;
      if (ALU_FunSel inside {4'b0100, 4'b0110, 4'b0111, 4'b1000}) z <= (alu_out == 8'h00);
    end
  end

  // ---------------- instruction-level reference ----------------
  logic [7:0] m_mem [256];
  logic [7:0] m_r [4];
  logic [7:0] m_ar, m_pc;
  logic       m_z, m_halt;

  task automatic isa_run(input int k);
    logic [15:0] w;
    logic [1:0]  d, s;
    logic [7:0]  imm;
    for (int i = 0; i < 256; i++) m_mem[i] = img[i];
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_ar = 8'h00; m_pc = 8'h00; m_z = 1'b0; m_halt = 1'b0;
    for (int n = 0; n < k && !m_halt; n++) begin
      w    = {m_mem[8'(m_pc + 8'd1)], m_mem[m_pc]};
      m_pc = m_pc + 8'd2;
      d = w[11:10]; s = w[9:8]; imm = w[7:0];
      case (w[15:12])
        4'h0: m_r[d] = imm;
        4'h1: m_r[d] = m_mem[m_ar];
        4'h2: m_mem[m_ar] = m_r[s];
        4'h3: begin m_r[d] = m_r[d] + m_r[s]; m_z = (m_r[d] == 8'h00); end
        4'h4: begin m_r[d] = m_r[d] - m_r[s]; m_z = (m_r[d] == 8'h00); end
        4'h5: begin m_r[d] = m_r[d] & m_r[s]; m_z = (m_r[d] == 8'h00); end
        4'h6: begin m_r[d] = m_r[d] | m_r[s]; m_z = (m_r[d] == 8'h00); end
        4'h7: m_ar = imm;
        4'h8: m_pc = imm;
        4'h9: if (m_z) m_pc = imm;
        4'hA: m_r[d] = m_r[d] + 8'd1;
        4'hB: m_r[d] = m_r[d] - 8'd1;
        4'hF: m_halt = 1'b1;
        default: ;
      endcase
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cs"}, 64'(Mem_CS), 64'd1);
    chk({tag, "_ctl"}, 64'(rest_out), 64'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic reset_dut(input bit reload);
    Reset = 1'b0;
    dp_load = reload;
    tick(1);
    dp_load = 1'b0;
    tick(1);
    Reset = 1'b1;
    #1;
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] d,
                                      input logic [1:0] s, input logic [7:0] imm);
    return {op, d, s, imm};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic put_word(input int idx, input logic [15:0] w);
    img[2*idx]   = w[7:0];
    img[2*idx+1] = w[15:8];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int active, guard, bad;
    n_tests = 0; n_fail = 0;
    Run = 1'b1; Reset = 1'b0; dp_load = 1'b1;
    clear_img();
    put_word(0, ins(4'h0, 2'd2, 2'd3, 8'h2A));

    // Reset state and first instruction LDI R3,0x2A
    tick(1);
    dp_load = 1'b0;
    check_idle("rst");
    chk("rst_sc", 64'(SC), 64'd3);
    chk("rst_halted", 64'(Halted), 64'd0);
    tick(1);
    Reset = 1'b1;
    #1;
    chk("clr_arf", 64'({ARF_RegSel, ARF_FunSel}), 64'({3'b111, 2'b11}));
    chk("clr_rf", 64'({RF_RegSel, RF_FunSel}), 64'({4'hF, 2'b11}));
    chk("clr_sc", 64'(SC), 64'd3);
    tick(1);
    chk("fl_sc", 64'(SC), 64'd0);
    chk("fl_ctl", 64'({Mem_CS, ARF_OutDSel, IR_Enable, IR_LH, IR_Funsel, ARF_RegSel, ARF_FunSel}),
        64'({1'b0, 2'b10, 1'b1, 1'b0, 2'b10, 3'b001, 2'b01}));
    chk("fl_pc", 64'(pc), 64'd0);
    chk("fl_r4", 64'(rf[3]), 64'd0);
    tick(1);
    chk("fh_sc", 64'(SC), 64'd1);
    chk("fh_lh", 64'({IR_LH, IR_Enable}), 64'd3);
    chk("fh_pc", 64'(pc), 64'd1);
    tick(1);
    chk("ex_sc", 64'(SC), 64'd2);
    chk("ex_ir", 64'(IR_In), 64'h0B2A);
    chk("ldi_ctl", 64'({MuxASel, RF_FunSel, RF_RegSel}), 64'({2'b10, 2'b10, 4'b0100}));
    tick(1);
    chk("ldi_sc", 64'(SC), 64'd0);
    chk("ldi_r3", 64'(rf[2]), 64'h2A);
    chk("ldi_pc", 64'(pc), 64'd2);

    // Run dropped for five cycles during FETCH_H
    reset_dut(1'b1);
    tick(2);
    Run = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_sc", 64'(SC), 64'd1);
      chk("hold_ire", 64'(IR_Enable), 64'd0);
      chk("hold_cs", 64'(Mem_CS), 64'd1);
      tick(1);
    end
    chk("hold_pc", 64'(pc), 64'd1);
    Run = 1'b1;
    #1;
    chk("resume_ire", 64'(IR_Enable), 64'd1);
    tick(1);
    chk("resume_sc", 64'(SC), 64'd2);
    tick(1);
    chk("resume_r3", 64'(rf[2]), 64'h2A);
    chk("resume_pc", 64'(pc), 64'd2);

    // BZ taken: R1 - R2 == 0
    clear_img();
    put_word(0, ins(4'h0, 2'd0, 2'd0, 8'h07));
    put_word(1, ins(4'h0, 2'd1, 2'd0, 8'h07));
    put_word(2, ins(4'h4, 2'd0, 2'd1, 8'h00));
    put_word(3, ins(4'h9, 2'd0, 2'd0, 8'h20));
    reset_dut(1'b1);
    tick(12);
    chk("bzt_sc", 64'(SC), 64'd2);
    chk("bzt_z", 64'(Z_Flag), 64'd1);
    chk("bzt_ctl", 64'({ARF_RegSel, ARF_FunSel, MuxBSel}), 64'({3'b001, 2'b10, 2'b10}));
    tick(1);
    chk("bzt_pc", 64'(pc), 64'h20);
    chk("bzt_r1", 64'(rf[0]), 64'd0);

    // BZ not taken: R2 = 6
    put_word(1, ins(4'h0, 2'd1, 2'd0, 8'h06));
    reset_dut(1'b1);
    tick(12);
    chk("bzn_z", 64'(Z_Flag), 64'd0);
    chk("bzn_arf", 64'(ARF_RegSel), 64'd0);
    check_idle("bzn");
    tick(1);
    chk("bzn_pc", 64'(pc), 64'd8);
    chk("bzn_r1", 64'(rf[0]), 64'd1);

    // HLT at PC=4, then restart via reset
    clear_img();
    put_word(0, ins(4'h0, 2'd0, 2'd0, 8'h11));
    put_word(1, ins(4'h0, 2'd1, 2'd0, 8'h22));
    put_word(2, ins(4'hF, 2'd0, 2'd0, 8'h00));
    reset_dut(1'b1);
    tick(10);
    for (int k = 0; k < 20; k++) begin
      chk("halt_flag", 64'(Halted), 64'd1);
      chk("halt_sc", 64'(SC), 64'd3);
      check_idle("halt");
      tick(1);
    end
    chk("halt_pc", 64'(pc), 64'd6);
    chk("halt_r2", 64'(rf[1]), 64'h22);
    Reset = 1'b0;
    #1;
    chk("halt_rst_flag", 64'(Halted), 64'd0);
    tick(1);
    Reset = 1'b1;
    #1;
    chk("rst2_clr", 64'({RF_RegSel, ARF_RegSel}), 64'({4'hF, 3'b111}));
    tick(1);
    chk("rst2_pc", 64'(pc), 64'd0);
    chk("rst2_sc", 64'(SC), 64'd0);
    tick(3);
    chk("rst2_r1", 64'(rf[0]), 64'h11);
    chk("rst2_pc2", 64'(pc), 64'd2);

    // Reset asserted during EXEC of ADD
    clear_img();
    put_word(0, ins(4'h0, 2'd0, 2'd0, 8'h03));
    put_word(1, ins(4'h0, 2'd1, 2'd0, 8'h04));
    put_word(2, ins(4'h3, 2'd0, 2'd1, 8'h00));
    reset_dut(1'b1);
    tick(9);
    chk("add_ctl", 64'({SC, ALU_FunSel, RF_RegSel}), 64'({2'd2, 4'b0100, 4'b0001}));
    Reset = 1'b0;
    #1;
    check_idle("midrst");
    chk("midrst_sc", 64'(SC), 64'd3);
    tick(1);
    chk("midrst_r1", 64'(rf[0]), 64'd3);
    Reset = 1'b1;
    #1;
    chk("midrst_clr", 64'(RF_RegSel), 64'hF);
    tick(1);
    chk("midrst_pc", 64'(pc), 64'd0);
    chk("midrst_r1b", 64'(rf[0]), 64'd0);

    // Random programs with random Run gaps against the instruction-level model
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      isa_run(15);
      Run = 1'b1;
      reset_dut(1'b1);
      active = 0;
      guard = 0;
      while (active < 46 && guard < 1000) begin
        Run = ($urandom_range(0, 3) != 0);
        if (Run) active++;
        guard++;
        tick(1);
      end
      Run = 1'b1;
      #1;
      chk($sformatf("rnd%0d_bound", t), 64'(active), 64'd46);
      for (int i = 0; i < 4; i++) chk($sformatf("rnd%0d_r%0d", t, i + 1), 64'(rf[i]), 64'(m_r[i]));
      chk($sformatf("rnd%0d_ar", t), 64'(ar), 64'(m_ar));
      chk($sformatf("rnd%0d_pc", t), 64'(pc), 64'(m_pc));
      chk($sformatf("rnd%0d_halted", t), 64'(Halted), 64'(m_halt));
      chk($sformatf("rnd%0d_sc", t), 64'(SC), m_halt ? 64'd3 : 64'd0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) bad++;
      chk($sformatf("rnd%0d_mem", t), 64'(bad), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
